cmos_dvp_pack: RTL and testbench

CMOS_DVP_PACK -- requirements
Module: cmos_dvp_pack

---
 rtl/cmos_pkg.sv | 20 ++
 rtl/cmos_dvp_pack.sv | 168 ++++++++++++++++
 tb/tb_cmos_dvp_pack.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmos_pkg.sv
// Shared types and widths for the CMOS DVP byte-to-pixel packer.
package cmos_pkg;

    localparam int unsigned CNT_W  = 12;
    localparam int unsigned SKIP_W = 4;
    localparam int unsigned PIX_W  = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_RUN  = 2'd2
    } dvp_state_t;

    // Saturating increment for the 12-bit pixel and line counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cmos_dvp_pack.sv
// DVP byte stream to RGB565 pixel packer with start-up frame skipping.
// Optional CMOS_DVP_STAT_EN adds line_len / frame_lines statistics outputs.
module cmos_dvp_pack
    import cmos_pkg::*;
#(
    parameter logic [SKIP_W-1:0] SKIP_FRAMES = 4'd10,
    parameter logic [CNT_W-1:0]  H_PIX       = 12'd640,
    parameter logic              HI_FIRST    = 1'b1
) (
    input  logic              pixel_clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] cmos_data,
    input  logic              cmos_href,
    input  logic              cmos_vsync,
    output logic [PIX_W-1:0]  pdata_o,
    output logic              de_o,
    output logic              vs_o,
    output logic              frame_ok,
    output logic              line_err
`ifdef CMOS_DVP_STAT_EN
    ,
    output logic [CNT_W-1:0]  line_len,
    output logic [CNT_W-1:0]  frame_lines
`endif
);

    logic [BYTE_W-1:0] data_d1;
    logic              href_d1;
    logic              vsync_d1;
    logic              href_q;
    logic              vsync_q;
    logic              phase;
    logic [BYTE_W-1:0] byte_lat;
    logic [CNT_W-1:0]  pix_cnt;

    dvp_state_t        state;
    dvp_state_t        state_next;
    logic [SKIP_W-1:0] skip_cnt;
    logic [SKIP_W-1:0] skip_cnt_next;

    logic byte_vld;
    logic pair_done;
    logic vs_rise;
    logic href_rise;
    logic href_fall;
    logic run_next;

    // Bytes count only while href is high outside vsync.
    assign byte_vld  = href_d1 && !vsync_d1;
    assign pair_done = byte_vld && phase;
    assign vs_rise   = vsync_d1 && !vsync_q;
    assign href_rise = href_d1 && !href_q;
    assign href_fall = !href_d1 && href_q;
    // Gate on the upcoming state so vs_o is complete on the first RUN frame.
    assign run_next  = (state_next == ST_RUN);

    // State register.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_cnt_next;
        end
    end

    // Frame gating: discard SKIP_FRAMES whole frames after reset.
    always_comb begin
        state_next    = state;
        skip_cnt_next = skip_cnt;
        case (state)
            ST_IDLE: begin
                if (vs_rise) begin
                    skip_cnt_next = '0;
                    state_next    = (SKIP_FRAMES == '0) ? ST_RUN : ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (vs_rise) begin
                    if ((skip_cnt + SKIP_W'(1)) == SKIP_FRAMES) begin
                        state_next = ST_RUN;
                    end else begin
                        skip_cnt_next = skip_cnt + SKIP_W'(1);
                    end
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Input stage, byte phase, first-byte latch and pixel counter.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_d1  <= '0;
            href_d1  <= 1'b0;
            vsync_d1 <= 1'b0;
            href_q   <= 1'b0;
            vsync_q  <= 1'b0;
            phase    <= 1'b0;
            byte_lat <= '0;
            pix_cnt  <= '0;
        end else begin
            data_d1  <= cmos_data;
            href_d1  <= cmos_href;
            vsync_d1 <= cmos_vsync;
            href_q   <= href_d1;
            vsync_q  <= vsync_d1;
            phase    <= byte_vld ? ~phase : 1'b0;
            if (byte_vld && !phase) begin
                byte_lat <= data_d1;
            end
            if (href_rise) begin
                pix_cnt <= '0;
            end else if (pair_done) begin
                pix_cnt <= sat_inc(pix_cnt);
            end
        end
    end

    // Registered outputs; a trailing unpaired byte never reaches pdata_o.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            pdata_o  <= '0;
            de_o     <= 1'b0;
            vs_o     <= 1'b0;
            frame_ok <= 1'b0;
            line_err <= 1'b0;
        end else begin
            de_o     <= run_next && pair_done;
            vs_o     <= run_next && vsync_d1;
            frame_ok <= run_next;
            line_err <= run_next && href_fall && (phase || (pix_cnt != H_PIX));
            if (run_next && pair_done) begin
                pdata_o <= HI_FIRST ? {byte_lat, data_d1} : {data_d1, byte_lat};
            end
        end
    end

`ifdef CMOS_DVP_STAT_EN
    logic [CNT_W-1:0] line_cnt;

    // Line length at each href fall; line count per frame at each vsync rise.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            line_len    <= '0;
            frame_lines <= '0;
            line_cnt    <= '0;
        end else begin
            if (href_fall) begin
                line_len <= pix_cnt;
            end
            if (vs_rise) begin
                frame_lines <= line_cnt;
                line_cnt    <= href_rise ? CNT_W'(1) : '0;
            end else if (href_rise) begin
                line_cnt <= sat_inc(line_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmos_dvp_pack.sv
// Directed self-checking bench for cmos_dvp_pack (two instances: HI_FIRST 1 and 0).
module tb_cmos_dvp_pack;

    logic        pixel_clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cmos_data;
    logic        cmos_href;
    logic        cmos_vsync;

    logic [15:0] pdata_o;
    logic        de_o;
    logic        vs_o;
    logic        frame_ok;
    logic        line_err;
    logic [15:0] pdata_lo;
    logic        de_lo;
    logic        vs_lo;
    logic        frame_ok_lo;
    logic        line_err_lo;
`ifdef CMOS_DVP_STAT_EN
    logic [11:0] line_len;
    logic [11:0] frame_lines;
    logic [11:0] line_len_lo;
    logic [11:0] frame_lines_lo;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pixel_clk = ~pixel_clk;

    cmos_dvp_pack #(
        .SKIP_FRAMES (4'd2),
        .H_PIX       (12'd640),
        .HI_FIRST    (1'b1)
    ) dut (
        .pixel_clk  (pixel_clk),
        .rst_n      (rst_n),
        .cmos_data  (cmos_data),
        .cmos_href  (cmos_href),
        .cmos_vsync (cmos_vsync),
        .pdata_o    (pdata_o),
        .de_o       (de_o),
        .vs_o       (vs_o),
        .frame_ok   (frame_ok),
        .line_err   (line_err)
`ifdef CMOS_DVP_STAT_EN
        ,
        .line_len    (line_len),
        .frame_lines (frame_lines)
`endif
    );

    cmos_dvp_pack #(
        .SKIP_FRAMES (4'd0),
        .H_PIX       (12'd640),
        .HI_FIRST    (1'b0)
    ) dut_lo (
        .pixel_clk  (pixel_clk),
        .rst_n      (rst_n),
        .cmos_data  (cmos_data),
        .cmos_href  (cmos_href),
        .cmos_vsync (cmos_vsync),
        .pdata_o    (pdata_lo),
        .de_o       (de_lo),
        .vs_o       (vs_lo),
        .frame_ok   (frame_ok_lo),
        .line_err   (line_err_lo)
`ifdef CMOS_DVP_STAT_EN
        ,
        .line_len    (line_len_lo),
        .frame_lines (frame_lines_lo)
`endif
    );

    // Running totals sampled on the falling edge.
    int   de_tot     = 0;
    int   vs_tot     = 0;
    int   err_tot    = 0;
    int   de_lo_tot  = 0;
    int   consec_tot = 0;
    logic de_prev    = 1'b0;

    always @(negedge pixel_clk) begin
        de_tot    <= de_tot + (de_o ? 1 : 0);
        vs_tot    <= vs_tot + (vs_o ? 1 : 0);
        err_tot   <= err_tot + (line_err ? 1 : 0);
        de_lo_tot <= de_lo_tot + (de_lo ? 1 : 0);
        if (de_o && de_prev) begin
            consec_tot <= consec_tot + 1;
        end
        de_prev <= de_o;
    end

    int b_de;
    int b_vs;
    int b_err;
    int b_de_lo;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_de    = de_tot;
        b_vs    = vs_tot;
        b_err   = err_tot;
        b_de_lo = de_lo_tot;
    endtask

    // Present one input cycle; returns 1 time unit after the sampling edge.
    task automatic drive(input logic [7:0] d, input logic h, input logic v);
        cmos_data  = d;
        cmos_href  = h;
        cmos_vsync = v;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic vsync_pulse();
        repeat (3) drive(8'h00, 1'b0, 1'b1);
        idle(4);
    endtask

    task automatic send_line(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            drive(8'(i * 7 + 3), 1'b1, 1'b0);
        end
        idle(4);
    endtask

    task automatic frame(input int nlines, input int nbytes);
        vsync_pulse();
        for (int l = 0; l < nlines; l++) begin
            send_line(nbytes);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        cmos_data  = 8'h00;
        cmos_href  = 1'b0;
        cmos_vsync = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1;
        check_eq("rst_pdata",    32'(pdata_o),  32'd0);
        check_eq("rst_de",       32'(de_o),     32'd0);
        check_eq("rst_vs",       32'(vs_o),     32'd0);
        check_eq("rst_frame_ok", 32'(frame_ok), 32'd0);
        check_eq("rst_line_err", 32'(line_err), 32'd0);
        rst_n = 1'b1;
        idle(3);

        // Frames 1 and 2 are discarded by dut; dut_lo runs from frame 1.
        snap();
        frame(4, 1280);
        check_eq("f1_de",         32'(de_tot - b_de),       32'd0);
        check_eq("f1_vs",         32'(vs_tot - b_vs),       32'd0);
        check_eq("f1_frame_ok",   32'(frame_ok),            32'd0);
        check_eq("f1_lo_de",      32'(de_lo_tot - b_de_lo), 32'd2560);
        check_eq("f1_lo_frameok", 32'(frame_ok_lo),         32'd1);
        snap();
        frame(4, 1280);
        check_eq("f2_de",       32'(de_tot - b_de), 32'd0);
        check_eq("f2_frame_ok", 32'(frame_ok),      32'd0);

        // Frame 3: RUN entered on the third vsync edge.
        snap();
        drive(8'h00, 1'b0, 1'b1);
        check_eq("f3_ok_before", 32'(frame_ok), 32'd0);
        drive(8'h00, 1'b0, 1'b1);
        check_eq("f3_ok_rise", 32'(frame_ok), 32'd1);
        drive(8'h00, 1'b0, 1'b1);
        idle(4);
        for (int l = 0; l < 4; l++) begin
            send_line(1280);
        end
        check_eq("f3_de",     32'(de_tot - b_de),   32'd2560);
        check_eq("f3_vs",     32'(vs_tot - b_vs),   32'd3);
        check_eq("f3_err",    32'(err_tot - b_err), 32'd0);
        check_eq("f3_consec", 32'(consec_tot),      32'd0);

        // Single pair F8,1F: de_o two cycles after the second byte.
        drive(8'hF8, 1'b1, 1'b0);
        drive(8'h1F, 1'b1, 1'b0);
        check_eq("pair_de_early", 32'(de_o), 32'd0);
        drive(8'h00, 1'b0, 1'b0);
        check_eq("pair_de",       32'(de_o),     32'd1);
        check_eq("pair_hi_first", 32'(pdata_o),  32'h0000F81F);
        check_eq("pair_lo_de",    32'(de_lo),    32'd1);
        check_eq("pair_lo_first", 32'(pdata_lo), 32'h00001FF8);
        drive(8'h00, 1'b0, 1'b0);
        check_eq("pair_de_off", 32'(de_o),    32'd0);
        check_eq("pair_hold",   32'(pdata_o), 32'h0000F81F);
        idle(6);

        // 1281-byte line: trailing byte dropped, one line_err at href fall.
        snap();
        for (int i = 0; i < 1281; i++) begin
            drive(8'(i * 7 + 3), 1'b1, 1'b0);
        end
        drive(8'h00, 1'b0, 1'b0);
        check_eq("odd_err_t2", 32'(line_err), 32'd0);
        drive(8'h00, 1'b0, 1'b0);
        check_eq("odd_err_t3", 32'(line_err), 32'd1);
        drive(8'h00, 1'b0, 1'b0);
        check_eq("odd_err_t4", 32'(line_err), 32'd0);
        idle(3);
        check_eq("odd_de",  32'(de_tot - b_de),   32'd640);
        check_eq("odd_err", 32'(err_tot - b_err), 32'd1);

        // href high during vsync: no pixels, phase held at 0, pairing intact after.
        snap();
        for (int i = 0; i < 5; i++) begin
            drive(8'(8'h30 + i), 1'b1, 1'b1);
        end
        check_eq("vh_phase", 32'(dut.phase), 32'd0);
        drive(8'hA5, 1'b1, 1'b0);
        drive(8'h5A, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        check_eq("vh_pair_de",   32'(de_o),    32'd1);
        check_eq("vh_pair_data", 32'(pdata_o), 32'h0000A55A);
        idle(4);
        check_eq("vh_de_count", 32'(de_tot - b_de), 32'd1);

        // Reset mid-line in RUN: outputs clear at once, SKIP sequence repeats.
        for (int i = 0; i < 100; i++) begin
            drive(8'(i * 7 + 3), 1'b1, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_pdata",    32'(pdata_o),  32'd0);
        check_eq("mid_rst_de",       32'(de_o),     32'd0);
        check_eq("mid_rst_frame_ok", 32'(frame_ok), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        snap();
        frame(4, 1280);
        frame(4, 1280);
        check_eq("rs_skip_de", 32'(de_tot - b_de), 32'd0);
        check_eq("rs_skip_ok", 32'(frame_ok),      32'd0);
        snap();
        frame(4, 1280);
        check_eq("rs_run_ok", 32'(frame_ok),       32'd1);
        check_eq("rs_run_de", 32'(de_tot - b_de),  32'd2560);
        check_eq("all_consec", 32'(consec_tot),    32'd0);

`ifdef CMOS_DVP_STAT_EN
        // 480-line frame: 479 short lines then a full 640-pixel line.
        vsync_pulse();
        for (int l = 0; l < 479; l++) begin
            send_line(4);
        end
        send_line(1280);
        check_eq("stat_line_len", 32'(line_len), 32'd640);
        vsync_pulse();
        check_eq("stat_frame_lines", 32'(frame_lines), 32'd480);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
